dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: port 0 (CPU load/store path) and port 1 (debug/loader engine).
- Round-robin ownership with a per-owner burst limit.
- Drives the memory enable/read/write strobes, address and write data.
- Registers read data back to the owning requester.
- Rejects out-of-range word addresses without touching memory.

Parameters:
- BURST_MAX, 4, max consecutive accesses by one owner while the other port is requesting (>=1)
- ADDR_WORDS, 1024, number of valid word addresses; addr >= ADDR_WORDS is an error access

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req0  in  1  port 0 access request; held with we0/addr0/wdata0 stable until ack0
- we0  in  1  port 0: 1 = write, 0 = read
- addr0  in  32  port 0 word address
- wdata0  in  32  port 0 write data
- ack0  out  1  port 0 access performed this cycle
- err0  out  1  with ack0: address out of range, no memory effect
- rvalid0  out  1  port 0 read data valid (cycle after a read ack)
- rdata0  out  32  port 0 read data
- req1, we1, addr1, wdata1, ack1, err1, rvalid1, rdata1: same as port 0, for port 1
- DM_ena  out  1  memory enable
- DM_R  out  1  memory read strobe
- DM_W  out  1  memory write strobe
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data (combinational from mem_addr)

Behaviour:
- States:
  - IDLE: no owner.
  - OWN0 / OWN1: port owns the memory.
- Registers:
  - cnt: accesses by current owner, width clog2(BURST_MAX)+1.
  - last: last owner.
- Reset (rst high at an edge):
  - state=IDLE, cnt=0, last=1 (port 0 wins first tie).
  - rvalid0/1=0, rdata0/1=0.
- Combinational gating while rst is high:
  - DM_ena, DM_R, DM_W, ack*, err* forced 0.
  - This holds even mid-access: no memory write occurs in a reset cycle.
- Access cycle: state OWNx and reqx=1.
  - ackx=1 (combinational, same cycle).
  - In range (addrx < ADDR_WORDS): DM_ena=1, DM_R=~wex, DM_W=wex, mem_addr=addrx, mem_wdata=wdatax.
  - Out of range: errx=1, memory strobes 0.
  - Read access: rdatax <= mem_rdata (0 if err), rvalidx <= 1 at the edge. rvalidx is a 1-cycle pulse.
  - Write access: rvalidx <= 0.
- No access cycle:
  - DM_ena=DM_R=DM_W=0, mem_addr=0, mem_wdata=0.
  - Non-owner ack/err=0.
  - rdatax holds its value.
- IDLE transitions (no access in IDLE):
  - Only req0 -> OWN0.
  - Only req1 -> OWN1.
  - Both -> OWN(~last).
  - Neither -> stay IDLE.
  - Latency from IDLE: req at cycle N -> ack at N+1 -> rvalid at N+2.
- OWNx transitions; cnt_n = cnt + (reqx ? 1 : 0):
  - req_other and (cnt_n >= BURST_MAX or !reqx) -> OWN_other, cnt=0, last=x.
  - !req_other and !reqx -> IDLE, cnt=0, last=x.
  - Otherwise stay, cnt = (cnt_n >= BURST_MAX) ? BURST_MAX : cnt_n (saturating).
- Throughput: the owner may access every cycle (back-to-back acks).
- Ownership parks with x while the other port is idle; cnt saturates, so there is no forced switch.
- Switching ownership costs no bubble when the new owner is already requesting.
- Request dropped before ack: no access, no ack, transitions as above.
- Ack is never asserted to both ports in one cycle.
- Writes and reads never overlap in one cycle.

Test Plan:
- Reset, then hold req0=1, we0=1, addr0=5, wdata0=0xDEADBEEF for 1 ack -> ack0 at cycle 1 after IDLE, DM_W=1, mem_addr=5. Then read addr0=5 -> rvalid0 pulse with rdata0=0xDEADBEEF one cycle after ack0.
- req0 and req1 both continuously reading from reset, BURST_MAX=4 -> ack pattern: 4x ack0, then 4x ack1, repeating. Never both acks in one cycle; first grant goes to port 0.
- Only port 1 requests 10 back-to-back reads -> 10 consecutive ack1 cycles with no switch. Then req0 rises -> port 1 keeps ownership for at most BURST_MAX further accesses, then ack0.
- req1 read at addr1=1024 -> ack1=1, err1=1, DM_ena=0. rvalid1 pulses next cycle with rdata1=0; memory contents unchanged.
- rst asserted in a cycle where OWN0 has req0 write to addr 7 -> DM_W=0 and no ack0 that cycle. Next cycle state IDLE, rvalid*=0; addr 7 retains its prior value.
- Simultaneous req0/req1 arriving in IDLE with last=0 -> OWN1 granted first. With last=1 -> OWN0 granted first.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: two requesters (0 = CPU, 1 = debug/loader) share one
// single-port memory with round-robin ownership and a per-owner burst limit.
// Out-of-range word addresses are acknowledged with err and never reach memory.
//
// state  | meaning
// -------+-----------------------------------------------
// S_IDLE | no owner; grants the next requester (tie -> not last)
// S_OWN0 | port 0 owns the memory and may access every cycle
// S_OWN1 | port 1 owns the memory and may access every cycle
module dmem_arbiter #(
  parameter int BURST_MAX  = 4,
  parameter int ADDR_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        we0,
  input  logic [31:0] addr0,
  input  logic [31:0] wdata0,
  output logic        ack0,
  output logic        err0,
  output logic        rvalid0,
  output logic [31:0] rdata0,
  input  logic        req1,
  input  logic        we1,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata1,
  output logic        ack1,
  output logic        err1,
  output logic        rvalid1,
  output logic [31:0] rdata1,
  output logic        DM_ena,
  output logic        DM_R,
  output logic        DM_W,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int          CW   = $clog2(BURST_MAX) + 1;
  localparam logic [CW:0] BMAX = (CW+1)'(BURST_MAX);
  localparam logic [31:0] ALIM = 32'(ADDR_WORDS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OWN0 = 2'd1,
    S_OWN1 = 2'd2
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_last;
  logic          r_rvalid0, r_rvalid1;
  logic [31:0]   r_rdata0, r_rdata1;

  logic          w_acc0, w_acc1;
  logic          w_inr0, w_inr1;
  logic          w_own_id, w_own_req, w_oth_req;
  logic [CW:0]   w_cnt_n;

  // Access qualification, strobes and memory bus; reset gates every strobe.
  always_comb begin
    w_inr0    = addr0 < ALIM;
    w_inr1    = addr1 < ALIM;
    w_acc0    = !rst && (r_state == S_OWN0) && req0;
    w_acc1    = !rst && (r_state == S_OWN1) && req1;
    w_own_id  = (r_state == S_OWN1);
    w_own_req = w_own_id ? req1 : req0;
    w_oth_req = w_own_id ? req0 : req1;
    w_cnt_n   = {1'b0, r_cnt} + {{CW{1'b0}}, w_own_req};

    ack0      = w_acc0;
    ack1      = w_acc1;
    err0      = w_acc0 && !w_inr0;
    err1      = w_acc1 && !w_inr1;
    DM_ena    = 1'b0;
    DM_R      = 1'b0;
    DM_W      = 1'b0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    if (w_acc0 && w_inr0) begin
      DM_ena    = 1'b1;
      DM_R      = !we0;
      DM_W      = we0;
      mem_addr  = addr0;
      mem_wdata = wdata0;
    end else if (w_acc1 && w_inr1) begin
      DM_ena    = 1'b1;
      DM_R      = !we1;
      DM_W      = we1;
      mem_addr  = addr1;
      mem_wdata = wdata1;
    end
  end

  // Ownership FSM, burst counter and registered read-data return.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_last    <= 1'b1;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      r_rdata0  <= 32'h0;
      r_rdata1  <= 32'h0;
    end else begin
      r_rvalid0 <= w_acc0 && !we0;
      r_rvalid1 <= w_acc1 && !we1;
      if (w_acc0 && !we0) r_rdata0 <= w_inr0 ? mem_rdata : 32'h0;
      if (w_acc1 && !we1) r_rdata1 <= w_inr1 ? mem_rdata : 32'h0;

      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (req0 && (!req1 || r_last)) r_state <= S_OWN0;
          else if (req1)                 r_state <= S_OWN1;
        end
        default: begin
          if (w_oth_req && ((w_cnt_n >= BMAX) || !w_own_req)) begin
            r_state <= w_own_id ? S_OWN0 : S_OWN1;
            r_cnt   <= '0;
            r_last  <= w_own_id;
          end else if (!w_oth_req && !w_own_req) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_last  <= w_own_id;
          end else begin
            // Parked owner saturates rather than wrapping, so no forced switch.
            r_cnt <= (w_cnt_n >= BMAX) ? BMAX[CW-1:0] : w_cnt_n[CW-1:0];
          end
        end
      endcase
    end
  end

  assign rvalid0 = r_rvalid0;
  assign rvalid1 = r_rvalid1;
  assign rdata0  = r_rdata0;
  assign rdata1  = r_rdata1;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios with literal expectations plus a
// cycle-level reference model of ownership, strobes, read return and memory.
module tb_dmem_arbiter;

  localparam int BM    = 4;
  localparam int WORDS = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, we0, req1, we1;
  logic [31:0] addr0, wdata0, addr1, wdata1;
  logic        ack0, err0, rvalid0, ack1, err1, rvalid1;
  logic [31:0] rdata0, rdata1;
  logic        DM_ena, DM_R, DM_W;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.BURST_MAX(BM), .ADDR_WORDS(WORDS)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .ack0(ack0), .err0(err0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .ack1(ack1), .err1(err1), .rvalid1(rvalid1), .rdata1(rdata1),
    .DM_ena(DM_ena), .DM_R(DM_R), .DM_W(DM_W),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] init_word(input int i);
    return 32'hA500_0000 + 32'(i);
  endfunction

  // Memory behind the arbiter: unwritten words read their init pattern.
  logic [31:0] tb_mem [0:WORDS-1];
  bit          tb_wr  [0:WORDS-1];

  always @(posedge clk) begin
    if (DM_ena && DM_W) begin
      tb_mem[mem_addr[9:0]] <= mem_wdata;
      tb_wr[mem_addr[9:0]]  <= 1'b1;
    end
  end

  always_comb begin
    mem_rdata = 32'h0;
    if (mem_addr < 32'(WORDS))
      mem_rdata = tb_wr[mem_addr[9:0]] ? tb_mem[mem_addr[9:0]] : init_word(int'(mem_addr[9:0]));
  end

  function automatic logic [31:0] tb_word(input int i);
    return tb_wr[i] ? tb_mem[i] : init_word(i);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: owner as an integer (-1 = none), burst count, last owner,
  // pending read returns and an image of the memory.
  int          m_owner = -1;
  int          m_cnt   = 0;
  int          m_last  = 1;
  bit          m_valid = 1'b0;
  logic        m_rvalid [2];
  logic [31:0] m_rdata  [2];
  logic [31:0] m_mem [0:WORDS-1];
  bit          m_wr  [0:WORDS-1];

  always @(negedge clk) begin : model
    logic        rq [2];
    logic        w  [2];
    logic [31:0] a  [2];
    logic [31:0] wd [2];
    logic        e_ack [2];
    logic        e_err [2];
    logic        e_ena, e_r, e_w;
    logic [31:0] e_addr, e_wdata;
    int          n, x, o;

    rq[0] = req0; w[0] = we0; a[0] = addr0; wd[0] = wdata0;
    rq[1] = req1; w[1] = we1; a[1] = addr1; wd[1] = wdata1;
    e_ena = 1'b0; e_r = 1'b0; e_w = 1'b0; e_addr = 32'h0; e_wdata = 32'h0;
    for (int p = 0; p < 2; p++) begin
      e_ack[p] = !rst && (m_owner == p) && rq[p];
      e_err[p] = e_ack[p] && (a[p] >= 32'(WORDS));
      if (e_ack[p] && !e_err[p]) begin
        e_ena = 1'b1; e_r = !w[p]; e_w = w[p]; e_addr = a[p]; e_wdata = wd[p];
      end
    end

    chk("m_ack0", 32'(ack0), 32'(e_ack[0]));
    chk("m_ack1", 32'(ack1), 32'(e_ack[1]));
    chk("m_err0", 32'(err0), 32'(e_err[0]));
    chk("m_err1", 32'(err1), 32'(e_err[1]));
    chk("m_ena", 32'(DM_ena), 32'(e_ena));
    chk("m_rd", 32'(DM_R), 32'(e_r));
    chk("m_wr", 32'(DM_W), 32'(e_w));
    chk("m_addr", mem_addr, e_addr);
    chk("m_wdata", mem_wdata, e_wdata);
    if (m_valid) begin
      chk("m_rvalid0", 32'(rvalid0), 32'(m_rvalid[0]));
      chk("m_rvalid1", 32'(rvalid1), 32'(m_rvalid[1]));
      chk("m_rdata0", rdata0, m_rdata[0]);
      chk("m_rdata1", rdata1, m_rdata[1]);
    end

    if (rst) begin
      m_owner = -1; m_cnt = 0; m_last = 1; m_valid = 1'b1;
      for (int p = 0; p < 2; p++) begin
        m_rvalid[p] = 1'b0; m_rdata[p] = 32'h0;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        m_rvalid[p] = e_ack[p] && !w[p];
        if (e_ack[p] && !w[p])
          m_rdata[p] = e_err[p] ? 32'h0 : (m_wr[a[p][9:0]] ? m_mem[a[p][9:0]] : init_word(int'(a[p][9:0])));
        if (e_ack[p] && w[p] && !e_err[p]) begin
          m_mem[a[p][9:0]] = wd[p];
          m_wr[a[p][9:0]]  = 1'b1;
        end
      end
      if (m_owner < 0) begin
        m_cnt = 0;
        if (rq[0] && rq[1]) m_owner = 1 - m_last;
        else if (rq[0])     m_owner = 0;
        else if (rq[1])     m_owner = 1;
      end else begin
        x = m_owner;
        o = 1 - x;
        n = m_cnt + (rq[x] ? 1 : 0);
        if (rq[o] && (n >= BM || !rq[x])) begin
          m_owner = o; m_cnt = 0; m_last = x;
        end else if (!rq[o] && !rq[x]) begin
          m_owner = -1; m_cnt = 0; m_last = x;
        end else begin
          m_cnt = (n >= BM) ? BM : n;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    step();
    rst = 1'b0;
  endtask

  int errs;

  initial begin
    rst = 1'b1;
    req0 = 1'b0; we0 = 1'b0; addr0 = 32'h0; wdata0 = 32'h0;
    req1 = 1'b0; we1 = 1'b0; addr1 = 32'h0; wdata1 = 32'h0;
    do_reset();

    // Write 0xDEADBEEF to word 5, then read it back.
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'd5; wdata0 = 32'hDEADBEEF;
    @(negedge clk);
    chk("t1_idle_ack0", 32'(ack0), 32'd0);
    chk("t1_idle_rvalid0", 32'(rvalid0), 32'd0);
    step();
    @(negedge clk);
    chk("t1_wr_ack0", 32'(ack0), 32'd1);
    chk("t1_wr_dmw", 32'(DM_W), 32'd1);
    chk("t1_wr_addr", mem_addr, 32'd5);
    chk("t1_wr_data", mem_wdata, 32'hDEADBEEF);
    step();
    we0 = 1'b0;
    @(negedge clk);
    chk("t1_rd_ack0", 32'(ack0), 32'd1);
    chk("t1_rd_dmr", 32'(DM_R), 32'd1);
    step();
    req0 = 1'b0;
    @(negedge clk);
    chk("t1_rvalid0", 32'(rvalid0), 32'd1);
    chk("t1_rdata0", rdata0, 32'hDEADBEEF);
    step();
    @(negedge clk);
    chk("t1_rvalid0_pulse", 32'(rvalid0), 32'd0);
    chk("t1_rdata0_hold", rdata0, 32'hDEADBEEF);
    step();

    // Both ports reading continuously: 4x port 0, 4x port 1, repeating.
    do_reset();
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'd5;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'd9;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      if (i == 0) begin
        chk("t2_idle_ack0", 32'(ack0), 32'd0);
        chk("t2_idle_ack1", 32'(ack1), 32'd0);
      end else begin
        chk("t2_rr_ack0", 32'(ack0), (((i - 1) / 4) % 2 == 0) ? 32'd1 : 32'd0);
        chk("t2_rr_ack1", 32'(ack1), (((i - 1) / 4) % 2 == 1) ? 32'd1 : 32'd0);
      end
      step();
    end
    req0 = 1'b0; req1 = 1'b0;
    step();

    // Port 1 parks for 10 reads; req0 then gets in after one more access.
    do_reset();
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'd3;
    for (int i = 0; i < 13; i++) begin
      if (i == 11) begin
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'd4;
      end
      @(negedge clk);
      chk("t3_ack1", 32'(ack1), (i >= 1 && i <= 11) ? 32'd1 : 32'd0);
      chk("t3_ack0", 32'(ack0), (i == 12) ? 32'd1 : 32'd0);
      step();
    end
    req0 = 1'b0; req1 = 1'b0;
    step();

    // Out-of-range read and write on port 1.
    do_reset();
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'd5;
    @(negedge clk);
    step();
    @(negedge clk);
    chk("t4_ok_ack1", 32'(ack1), 32'd1);
    chk("t4_ok_err1", 32'(err1), 32'd0);
    step();
    addr1 = 32'd1024;
    @(negedge clk);
    chk("t4_err_ack1", 32'(ack1), 32'd1);
    chk("t4_err_err1", 32'(err1), 32'd1);
    chk("t4_err_ena", 32'(DM_ena), 32'd0);
    chk("t4_prev_rdata1", rdata1, 32'hDEADBEEF);
    step();
    we1 = 1'b1; addr1 = 32'd1030; wdata1 = 32'hCAFEF00D;
    @(negedge clk);
    chk("t4_err_rvalid1", 32'(rvalid1), 32'd1);
    chk("t4_err_rdata1", rdata1, 32'h0);
    chk("t4_errw_dmw", 32'(DM_W), 32'd0);
    step();
    req1 = 1'b0;
    @(negedge clk);
    chk("t4_errw_rvalid1", 32'(rvalid1), 32'd0);
    step();
    chk("t4_mem6_untouched", tb_word(6), init_word(6));

    // Reset in the middle of a port-0 write burst to word 7.
    do_reset();
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'd7; wdata0 = 32'h11111111;
    @(negedge clk);
    step();
    @(negedge clk);
    chk("t5_wr_ack0", 32'(ack0), 32'd1);
    step();
    we0 = 1'b0;
    @(negedge clk);
    chk("t5_rd_ack0", 32'(ack0), 32'd1);
    step();
    rst = 1'b1; we0 = 1'b1; wdata0 = 32'h22222222;
    @(negedge clk);
    chk("t5_rst_ack0", 32'(ack0), 32'd0);
    chk("t5_rst_dmw", 32'(DM_W), 32'd0);
    chk("t5_rst_ena", 32'(DM_ena), 32'd0);
    chk("t5_pre_rst_rdata0", rdata0, 32'h11111111);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("t5_idle_ack0", 32'(ack0), 32'd0);
    chk("t5_idle_rvalid0", 32'(rvalid0), 32'd0);
    chk("t5_idle_rdata0", rdata0, 32'h0);
    step();
    req0 = 1'b0;
    @(negedge clk);
    step();
    chk("t5_mem7_kept", tb_word(7), 32'h11111111);

    // Tie-break after port 0 was last owner, then straight after reset.
    do_reset();
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'd2;
    @(negedge clk);
    step();
    @(negedge clk);
    chk("t6_single_ack0", 32'(ack0), 32'd1);
    step();
    req0 = 1'b0;
    @(negedge clk);
    step();
    req0 = 1'b1; req1 = 1'b1; we1 = 1'b0; addr1 = 32'd3;
    @(negedge clk);
    chk("t6_tie_idle_ack1", 32'(ack1), 32'd0);
    step();
    @(negedge clk);
    chk("t6_last0_ack1", 32'(ack1), 32'd1);
    chk("t6_last0_ack0", 32'(ack0), 32'd0);
    step();
    do_reset();
    req0 = 1'b1; req1 = 1'b1;
    @(negedge clk);
    step();
    @(negedge clk);
    chk("t6_last1_ack0", 32'(ack0), 32'd1);
    chk("t6_last1_ack1", 32'(ack1), 32'd0);
    step();
    req0 = 1'b0; req1 = 1'b0;
    step();
    step();

    errs = 0;
    for (int k = 0; k < WORDS; k++)
      if (tb_word(k) !== (m_wr[k] ? m_mem[k] : init_word(k))) errs++;
    chk("final_mem_image_diffs", 32'(errs), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
